// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package rvx10_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_CYCLES_DEF = 16;
    localparam int TIMEOUT_W          = $clog2(TIMEOUT_CYCLES_DEF + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack port: LSU is master, memory is slave.
interface mem_stage_lsu_if #(parameter int XLEN = 32);
    logic              req;
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] be;
    logic              ack;
    logic [XLEN-1:0]   rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering: store enables/replication, load extract/extend, misalign check.
module lsu_align
    import rvx10_mem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rdata[{addr, 3'b000} +: 8];
    assign rhalf = rdata[{addr[1], 4'b0000} +: 16];

    // Unsupported encodings fall through to the word defaults.
    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        misalign   = |addr;
        case (funct3)
            F3_B, F3_BU: begin
                be         = 4'b0001 << addr;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = (funct3 == F3_BU) ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
                misalign   = 1'b0;
            end
            F3_H, F3_HU: begin
                be         = 4'b0011 << {addr[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = (funct3 == F3_HU) ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
                misalign   = addr[0];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: IDLE/REQ/RESP handshake to data memory, stalls upstream while busy.
// Optional MEM_TIMEOUT_EN aborts a REQ that waits TIMEOUT_CYCLES without ack (BusErrM).
module mem_stage_lsu
    import rvx10_mem_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [2:0]      Funct3M,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    mem_stage_lsu_if.master dmem,
    output logic [XLEN-1:0] ReadDataM,
    output logic            StallM,
    output logic            MisalignM,
    output logic            BusErrM
);
    if (XLEN != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mem_stage_lsu: XLEN must be 32 and TIMEOUT_CYCLES >= 1");
    end

    lsu_state_t state;
    logic [1:0] addr_lo_q;
    logic [2:0] f3_q;
    logic       is_load_q;

    logic       access;
    logic [1:0] al_addr;
    logic [2:0] al_f3;
    logic [3:0] be_c;
    logic [31:0] wdata_c, rdata_ext;
    logic       mis_c;

    assign access = MemReadM | MemWriteM;

    // Live inputs steer lanes at issue; the latched copy drives load extraction.
    assign al_addr = (state == IDLE) ? ALUResultM[1:0] : addr_lo_q;
    assign al_f3   = (state == IDLE) ? Funct3M : f3_q;

    lsu_align u_align (
        .addr       (al_addr),
        .funct3     (al_f3),
        .wdata      (WriteDataM),
        .rdata      (dmem.rdata),
        .be         (be_c),
        .wdata_lane (wdata_c),
        .rdata_ext  (rdata_ext),
        .misalign   (mis_c)
    );

    always_comb begin
        MisalignM = (state == IDLE) && access && mis_c;
        StallM    = ((state == IDLE) && access && !mis_c) || (state == REQ);
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
`else
    assign BusErrM = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= '0;
            dmem.wdata <= '0;
            dmem.be    <= '0;
            ReadDataM  <= '0;
            addr_lo_q  <= '0;
            f3_q       <= '0;
            is_load_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt   <= '0;
            BusErrM    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (access && !mis_c) begin
                        state      <= REQ;
                        dmem.req   <= 1'b1;
                        dmem.we    <= MemWriteM;
                        dmem.addr  <= {ALUResultM[XLEN-1:2], 2'b00};
                        dmem.wdata <= wdata_c;
                        dmem.be    <= be_c;
                        addr_lo_q  <= ALUResultM[1:0];
                        f3_q       <= Funct3M;
                        is_load_q  <= MemReadM;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                    end
                end
                REQ: begin
                    if (dmem.ack) begin
                        state     <= RESP;
                        dmem.req  <= 1'b0;
                        ReadDataM <= is_load_q ? rdata_ext : '0;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= RESP;
                        dmem.req  <= 1'b0;
                        ReadDataM <= '0;
                        BusErrM   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state     <= IDLE;
                    ReadDataM <= '0;
`ifdef MEM_TIMEOUT_EN
                    BusErrM   <= 1'b0;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu; memory side is modelled by driving ack/rdata per vector.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ALUResultM = '0, WriteDataM = '0;
    logic [2:0]  Funct3M = '0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM, BusErrM;

    int errors = 0;
    int checks = 0;

    mem_stage_lsu_if #(.XLEN(32)) dmem_bus ();

    mem_stage_lsu #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .Funct3M    (Funct3M),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .dmem       (dmem_bus),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one access, acking on REQ cycle number `waits` (0 = same cycle). Call just after a posedge.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input int waits, input logic [31:0] rdat,
                          output int stall_cyc, output int req_cyc,
                          output logic [31:0] q_addr, output logic [31:0] q_wdata,
                          output logic [3:0] q_be, output logic q_we,
                          output logic [31:0] r_data, output logic r_buserr, output logic r_req);
        bit done = 0;
        stall_cyc = 0; req_cyc = 0;
        q_addr = 'x; q_wdata = 'x; q_be = 'x; q_we = 1'bx;
        r_data = 'x; r_buserr = 1'bx; r_req = 1'bx;
        MemReadM = rd; MemWriteM = wr; ALUResultM = a; WriteDataM = wd; Funct3M = f3;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (dmem_bus.req) begin
                if (req_cyc == 0) begin
                    q_addr = dmem_bus.addr; q_wdata = dmem_bus.wdata;
                    q_be = dmem_bus.be; q_we = dmem_bus.we;
                end
                dmem_bus.ack = (req_cyc == waits);
                dmem_bus.rdata = rdat;
                req_cyc++;
            end
            if (StallM) stall_cyc++;
            else if (stall_cyc > 0) begin
                r_data = ReadDataM; r_buserr = BusErrM; r_req = dmem_bus.req;
                done = 1;
            end
            @(posedge clk); #1;
            dmem_bus.ack = 1'b0;
        end
        MemReadM = 1'b0; MemWriteM = 1'b0;
        chk("access_done", 32'(done), 32'd1);
    endtask

    int sc, rc;
    logic [31:0] qa, qw, rdv;
    logic [3:0]  qb;
    logic        qwe, rbe, rrq;

    initial begin
        dmem_bus.ack = 1'b0;
        dmem_bus.rdata = '0;
        #2;
        chk("rst_req", 32'(dmem_bus.req), 0);
        chk("rst_addr", dmem_bus.addr, 0);
        chk("rst_be", 32'(dmem_bus.be), 0);
        chk("rst_rdata", ReadDataM, 0);
        chk("rst_stall", 32'(StallM), 0);
        chk("rst_buserr", 32'(BusErrM), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // sw 0xDEADBEEF @0x100, two wait cycles
        access(0, 1, 32'h100, 32'hDEADBEEF, 3'b010, 2, 32'h0, sc, rc, qa, qw, qb, qwe, rdv, rbe, rrq);
        chk("sw_addr", qa, 32'h100);
        chk("sw_be", 32'(qb), 32'hF);
        chk("sw_we", 32'(qwe), 1);
        chk("sw_wdata", qw, 32'hDEADBEEF);
        chk("sw_stall", sc, 4);
        chk("sw_reqcyc", rc, 3);
        chk("sw_rdata", rdv, 0);
        chk("sw_resp_req", 32'(rrq), 0);

        // lb / lbu @0x203, same-cycle ack
        access(1, 0, 32'h203, 32'h0, 3'b000, 0, 32'h80FF1234, sc, rc, qa, qw, qb, qwe, rdv, rbe, rrq);
        chk("lb_addr", qa, 32'h200);
        chk("lb_be", 32'(qb), 32'h8);
        chk("lb_we", 32'(qwe), 0);
        chk("lb_stall", sc, 2);
        chk("lb_data", rdv, 32'hFFFFFF80);
        access(1, 0, 32'h203, 32'h0, 3'b100, 0, 32'h80FF1234, sc, rc, qa, qw, qb, qwe, rdv, rbe, rrq);
        chk("lbu_data", rdv, 32'h00000080);

        // lh / lhu
        access(1, 0, 32'h202, 32'h0, 3'b001, 0, 32'h8001ABCD, sc, rc, qa, qw, qb, qwe, rdv, rbe, rrq);
        chk("lh_be", 32'(qb), 32'hC);
        chk("lh_data", rdv, 32'hFFFF8001);
        access(1, 0, 32'h200, 32'h0, 3'b101, 1, 32'h8001ABCD, sc, rc, qa, qw, qb, qwe, rdv, rbe, rrq);
        chk("lhu_data", rdv, 32'h0000ABCD);
        chk("lhu_stall", sc, 3);

        // lw @0x202: misaligned, never issued
        MemReadM = 1; ALUResultM = 32'h202; Funct3M = 3'b010;
        @(negedge clk);
        chk("lw_mis_flag", 32'(MisalignM), 1);
        chk("lw_mis_stall", 32'(StallM), 0);
        chk("lw_mis_req", 32'(dmem_bus.req), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lw_mis_req2", 32'(dmem_bus.req), 0);
        chk("lw_mis_rdata", ReadDataM, 0);
        MemReadM = 0;
        @(negedge clk);
        chk("mis_clear", 32'(MisalignM), 0);
        @(posedge clk); #1;

        // sh 0x1234ABCD @0x006
        access(0, 1, 32'h006, 32'h1234ABCD, 3'b001, 0, 32'h0, sc, rc, qa, qw, qb, qwe, rdv, rbe, rrq);
        chk("sh_addr", qa, 32'h004);
        chk("sh_be", 32'(qb), 32'hC);
        chk("sh_wdata", qw, 32'hABCDABCD);
        chk("sh_rdata", rdv, 0);

        // sb 0x...A5 @0x001; unsupported funct3 011 behaves as word
        access(0, 1, 32'h001, 32'h123456A5, 3'b000, 0, 32'h0, sc, rc, qa, qw, qb, qwe, rdv, rbe, rrq);
        chk("sb_be", 32'(qb), 32'h2);
        chk("sb_wdata", qw, 32'hA5A5A5A5);
        access(1, 0, 32'h010, 32'h0, 3'b011, 0, 32'hCAFEF00D, sc, rc, qa, qw, qb, qwe, rdv, rbe, rrq);
        chk("f3_011_be", 32'(qb), 32'hF);
        chk("f3_011_data", rdv, 32'hCAFEF00D);

        // reset asserted while in REQ
        MemReadM = 1; ALUResultM = 32'h40; Funct3M = 3'b010;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_req_before", 32'(dmem_bus.req), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_req_after", 32'(dmem_bus.req), 0);
        MemReadM = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        dmem_bus.ack = 1'b1; dmem_bus.rdata = 32'h55AA55AA;
        @(posedge clk); #1;
        dmem_bus.ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_req", 32'(dmem_bus.req), 0);
        chk("stray_ack_stall", 32'(StallM), 0);
        chk("stray_ack_rdata", ReadDataM, 0);
        @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
        // no ack: abort after 4 REQ cycles, then a back-to-back load
        access(1, 0, 32'h300, 32'h0, 3'b010, 1000, 32'h0, sc, rc, qa, qw, qb, qwe, rdv, rbe, rrq);
        chk("to_reqcyc", rc, 4);
        chk("to_stall", sc, 5);
        chk("to_buserr", 32'(rbe), 1);
        chk("to_rdata", rdv, 0);
        access(1, 0, 32'h304, 32'h0, 3'b010, 0, 32'h11223344, sc, rc, qa, qw, qb, qwe, rdv, rbe, rrq);
        chk("b2b_stall", sc, 2);
        chk("b2b_data", rdv, 32'h11223344);
        chk("b2b_buserr", 32'(rbe), 0);
        // ack on the limit cycle completes normally
        access(1, 0, 32'h308, 32'h0, 3'b010, 3, 32'h0BADF00D, sc, rc, qa, qw, qb, qwe, rdv, rbe, rrq);
        chk("lim_reqcyc", rc, 4);
        chk("lim_data", rdv, 32'h0BADF00D);
        chk("lim_buserr", 32'(rbe), 0);
`else
        // without the timeout, a long wait still completes
        access(1, 0, 32'h300, 32'h0, 3'b010, 20, 32'h11223344, sc, rc, qa, qw, qb, qwe, rdv, rbe, rrq);
        chk("long_reqcyc", rc, 21);
        chk("long_data", rdv, 32'h11223344);
        chk("long_buserr", 32'(rbe), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
